// File: rtl/paddle_pkg.sv
// Shared types and playfield constants for the paddle input controller.
package paddle_pkg;

  typedef enum logic [1:0] {
    WAIT_RELEASE = 2'd0,
    PLAY         = 2'd1,
    FROZEN       = 2'd2
  } ctrl_state_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam int PLAYFIELD_X_MAX = 639;
  localparam int PLAYFIELD_Y_MAX = 479;
  localparam int PADDLE_X_W      = 11;
  localparam int TURBO_LVL_W     = 6;

endpackage

// File: rtl/paddle_if.sv
// Key/feedback inputs and mover commands of the paddle controller.
interface paddle_if;
  import paddle_pkg::*;

  logic                         startOfFrame;
  logic                         keyLeft;
  logic                         keyRight;
  logic                         keyTurbo;
  logic                         freeze;
  logic signed [PADDLE_X_W-1:0] paddleX;
  logic                         Left;
  logic                         Right;
  logic                         Turbo;
  logic [TURBO_LVL_W-1:0]       turboLevel;
  logic                         turboExhausted;

  // master: keyboard/game/mover side; slave: the controller
  modport master (
    output startOfFrame, keyLeft, keyRight, keyTurbo, freeze, paddleX,
    input  Left, Right, Turbo, turboLevel, turboExhausted
  );

  modport slave (
    input  startOfFrame, keyLeft, keyRight, keyTurbo, freeze, paddleX,
    output Left, Right, Turbo, turboLevel, turboExhausted
  );

endinterface

// File: rtl/paddle_ctrl_turbo_meter.sv
// Per-frame turbo energy: drains while turbo is active, recharges one step
// every RECHARGE_DIV idle frames, and locks out turbo from empty until rearmed.
module turbo_meter
  import paddle_pkg::*;
#(
  parameter int TURBO_MAX    = 60,
  parameter int TURBO_REARM  = 20,
  parameter int RECHARGE_DIV = 4
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   drain,
  input  logic                   hold,
  output logic [TURBO_LVL_W-1:0] level,
  output logic                   exhausted
);

  localparam int CNT_W = (RECHARGE_DIV > 1) ? $clog2(RECHARGE_DIV) : 1;
  localparam logic [CNT_W-1:0]       CNT_LAST  = CNT_W'(RECHARGE_DIV - 1);
  localparam logic [TURBO_LVL_W-1:0] LVL_MAX   = TURBO_LVL_W'(TURBO_MAX);
  localparam logic [TURBO_LVL_W-1:0] LVL_REARM = TURBO_LVL_W'(TURBO_REARM);

  logic [CNT_W-1:0] rechargeCnt;

  // hold turns a frame that coincides with a freeze into a recharge frame
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      level       <= LVL_MAX;
      exhausted   <= 1'b0;
      rechargeCnt <= '0;
    end else if (startOfFrame) begin
      if (drain && !hold) begin
        if (level != '0) begin
          level <= level - 1'b1;
          if (level == TURBO_LVL_W'(1))
            exhausted <= 1'b1;
        end
      end else if (rechargeCnt == CNT_LAST) begin
        rechargeCnt <= '0;
        if (level < LVL_MAX) begin
          level <= level + 1'b1;
          if ((level + 1'b1) >= LVL_REARM)
            exhausted <= 1'b0;
        end
      end else begin
        rechargeCnt <= rechargeCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle input controller: key arbitration, wall clamp, freeze sequencing
// and turbo rationing, with registered Left/Right/Turbo commands.
//
//   state        | meaning
//   WAIT_RELEASE | outputs 0; waits for both direction keys up and no freeze
//   PLAY         | commands follow keys, arbitration and wall clamp
//   FROZEN       | outputs 0 while the game holds freeze
module paddle_ctrl
  import paddle_pkg::*;
#(
  parameter int X_MIN        = 0,
  parameter int X_MAX        = PLAYFIELD_X_MAX,
  parameter int PADDLE_W     = 64,
  parameter int TURBO_MAX    = 60,
  parameter int TURBO_REARM  = 20,
  parameter int RECHARGE_DIV = 4
) (
  input  logic     clk,
  input  logic     resetN,
  paddle_if.slave  pif
);

  localparam logic signed [11:0] X_MIN_S = 12'(X_MIN);
  localparam logic signed [11:0] X_MAX_S = 12'(X_MAX);
  localparam logic signed [11:0] PW_S    = 12'(PADDLE_W);

  ctrl_state_t       state, state_nxt;
  dir_t              lastDir, dir_eff;
  logic              keyLeft_d, keyRight_d;
  logic              riseLeft, riseRight;
  logic              want_l, want_r;
  logic              left_nxt, right_nxt, turbo_nxt;
  logic              left_ok, right_ok;
  logic signed [11:0] px_ext;

  assign riseLeft  = pif.keyLeft  & ~keyLeft_d;
  assign riseRight = pif.keyRight & ~keyRight_d;
  assign dir_eff   = riseRight ? DIR_RIGHT : (riseLeft ? DIR_LEFT : lastDir);

  assign px_ext   = {pif.paddleX[PADDLE_X_W-1], pif.paddleX};
  assign left_ok  = px_ext > X_MIN_S;
  assign right_ok = (px_ext + PW_S) < X_MAX_S;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= WAIT_RELEASE;
      lastDir    <= DIR_RIGHT;
      keyLeft_d  <= 1'b0;
      keyRight_d <= 1'b0;
      pif.Left   <= 1'b0;
      pif.Right  <= 1'b0;
      pif.Turbo  <= 1'b0;
    end else begin
      state      <= state_nxt;
      lastDir    <= dir_eff;
      keyLeft_d  <= pif.keyLeft;
      keyRight_d <= pif.keyRight;
      pif.Left   <= left_nxt;
      pif.Right  <= right_nxt;
      pif.Turbo  <= turbo_nxt;
    end
  end

  // Commands are decided against the next state so a freeze blanks them in one clk
  always_comb begin
    state_nxt = state;
    want_l    = pif.keyLeft;
    want_r    = pif.keyRight;
    left_nxt  = 1'b0;
    right_nxt = 1'b0;
    turbo_nxt = 1'b0;

    case (state)
      WAIT_RELEASE: if (!pif.keyLeft && !pif.keyRight && !pif.freeze) state_nxt = PLAY;
      PLAY:         if (pif.freeze) state_nxt = FROZEN;
      FROZEN:       if (!pif.freeze) state_nxt = WAIT_RELEASE;
      default:      state_nxt = WAIT_RELEASE;
    endcase

    if (pif.keyLeft && pif.keyRight) begin
      want_l = (dir_eff == DIR_LEFT);
      want_r = (dir_eff == DIR_RIGHT);
    end

    if (state_nxt == PLAY) begin
      left_nxt  = want_l & left_ok;
      right_nxt = want_r & right_ok;
      turbo_nxt = pif.keyTurbo & (left_nxt | right_nxt) & ~pif.turboExhausted;
    end
  end

  turbo_meter #(
    .TURBO_MAX    (TURBO_MAX),
    .TURBO_REARM  (TURBO_REARM),
    .RECHARGE_DIV (RECHARGE_DIV)
  ) u_turbo_meter (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (pif.startOfFrame),
    .drain        (pif.Turbo),
    .hold         (pif.freeze),
    .level        (pif.turboLevel),
    .exhausted    (pif.turboExhausted)
  );

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl: reset hold, arbitration, clamp, turbo drain/rearm, freeze.
module tb_paddle_ctrl;

  logic clk;
  logic resetN;
  int   nvec;
  int   nerr;

  paddle_if pif ();

  paddle_ctrl dut (
    .clk    (clk),
    .resetN (resetN),
    .pif    (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sof_pulse();
    pif.startOfFrame = 1'b1;
    tick();
    pif.startOfFrame = 1'b0;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    resetN           = 1'b0;
    pif.startOfFrame = 1'b0;
    pif.keyLeft      = 1'b0;
    pif.keyRight     = 1'b1;
    pif.keyTurbo     = 1'b0;
    pif.freeze       = 1'b0;
    pif.paddleX      = 11'sd300;

    // reset hold with Right key down
    repeat (3) tick();
    chk("rst_left",  pif.Left, 0);
    chk("rst_right", pif.Right, 0);
    chk("rst_turbo", pif.Turbo, 0);
    chk("rst_level", pif.turboLevel, 60);
    chk("rst_exh",   pif.turboExhausted, 0);
    resetN = 1'b1;
    repeat (3) tick();
    chk("hold_right", pif.Right, 0);
    pif.keyRight = 1'b0;
    tick();
    chk("released_right", pif.Right, 0);
    pif.keyRight = 1'b1;
    tick();
    chk("press_right", pif.Right, 1);

    // arbitration
    pif.keyRight = 1'b0;
    tick();
    pif.keyLeft = 1'b1;
    tick();
    chk("left_only", pif.Left, 1);
    repeat (10) tick();
    pif.keyRight = 1'b1;
    tick();
    chk("both_last_r_right", pif.Right, 1);
    chk("both_last_r_left",  pif.Left, 0);
    pif.keyRight = 1'b0;
    tick();
    chk("rel_right_left",  pif.Left, 1);
    chk("rel_right_right", pif.Right, 0);
    pif.keyLeft = 1'b0;
    tick();
    chk("none_left",  pif.Left, 0);
    chk("none_right", pif.Right, 0);
    pif.keyLeft  = 1'b1;
    pif.keyRight = 1'b1;
    tick();
    chk("same_rise_right", pif.Right, 1);
    chk("same_rise_left",  pif.Left, 0);
    pif.keyLeft  = 1'b0;
    pif.keyRight = 1'b0;
    tick();

    // wall clamp
    pif.keyRight = 1'b1;
    pif.paddleX  = 11'sd575;
    tick();
    chk("clamp_r_575", pif.Right, 0);
    pif.paddleX = 11'sd574;
    tick();
    chk("clamp_r_574", pif.Right, 1);
    pif.keyRight = 1'b0;
    pif.keyLeft  = 1'b1;
    pif.paddleX  = -11'sd3;
    tick();
    chk("clamp_l_neg3", pif.Left, 0);
    pif.paddleX = 11'sd1;
    tick();
    chk("clamp_l_1", pif.Left, 1);
    pif.paddleX = 11'sd0;
    tick();
    chk("clamp_l_0", pif.Left, 0);
    pif.keyLeft = 1'b0;
    pif.paddleX = 11'sd300;
    tick();

    // turbo drain 60 -> 0
    pif.keyRight = 1'b1;
    pif.keyTurbo = 1'b1;
    tick();
    chk("turbo_on", pif.Turbo, 1);
    for (int k = 1; k <= 59; k++) begin
      sof_pulse();
      chk("drain_level", pif.turboLevel, 60 - k);
      tick();
      tick();
    end
    chk("drain_exh_59", pif.turboExhausted, 0);
    sof_pulse();
    chk("drain_level_0", pif.turboLevel, 0);
    chk("drain_exh",     pif.turboExhausted, 1);
    chk("turbo_same_clk", pif.Turbo, 1);
    tick();
    chk("turbo_dropped", pif.Turbo, 0);
    chk("right_kept",    pif.Right, 1);
    pif.keyRight = 1'b0;
    pif.keyTurbo = 1'b0;
    tick();

    // rearm: one level step per 4 idle frames
    for (int k = 1; k <= 80; k++) begin
      sof_pulse();
      chk("rearm_level", pif.turboLevel, k / 4);
      chk("rearm_exh",   pif.turboExhausted, (k < 80) ? 1 : 0);
      tick();
    end

    // freeze mid-turbo
    pif.keyRight = 1'b1;
    pif.keyTurbo = 1'b1;
    tick();
    chk("turbo_rearmed", pif.Turbo, 1);
    sof_pulse();
    chk("pre_freeze_level", pif.turboLevel, 19);
    tick();
    pif.freeze = 1'b1;
    sof_pulse();
    chk("frz_left",  pif.Left, 0);
    chk("frz_right", pif.Right, 0);
    chk("frz_turbo", pif.Turbo, 0);
    chk("frz_level", pif.turboLevel, 19);
    for (int k = 0; k < 3; k++) begin
      tick();
      sof_pulse();
    end
    chk("frz_recharge", pif.turboLevel, 20);
    pif.freeze = 1'b0;
    repeat (3) tick();
    chk("unfrz_right_held", pif.Right, 0);
    chk("unfrz_turbo_held", pif.Turbo, 0);
    pif.keyRight = 1'b0;
    pif.keyTurbo = 1'b0;
    tick();
    pif.keyRight = 1'b1;
    tick();
    chk("replay_right", pif.Right, 1);

    // asynchronous reset mid-operation
    resetN = 1'b0;
    #2;
    chk("async_rst_right", pif.Right, 0);
    chk("async_rst_level", pif.turboLevel, 60);
    resetN = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/paddle_ctrl.md
# paddle_ctrl

Input controller that sits between the debounced keyboard strobes and the paddle mover. It arbitrates the left/right keys with a last-pressed-wins rule and stops the paddle at the playfield walls using the paddle X position fed back from the mover. It rations turbo through a per-frame energy meter and freezes paddle motion during game events (life lost, level start). Its three registered outputs drive the mover's `Left`, `Right` and `Turbo` inputs; it also exports the turbo level for the HUD.

## Interface
Parameters:
- `X_MIN`, 0: leftmost allowed paddle top-left X, in pixels.
- `X_MAX`, 639: rightmost allowed paddle right edge, in pixels.
- `PADDLE_W`, 64: paddle width, in pixels.
- `TURBO_MAX`, 60: full turbo energy, in frames; must be ≤ 63.
- `TURBO_REARM`, 20: energy level required to leave the exhausted condition.
- `RECHARGE_DIV`, 4: frames per +1 recharge step.

Ports:
- `clk`  in  1: system clock.
- `resetN`  in  1: asynchronous, active-low reset.
- `startOfFrame`  in  1: one-cycle pulse per video frame.
- `keyLeft`, `keyRight`, `keyTurbo`  in  1 each: debounced key levels.
- `freeze`  in  1: level from the game FSM; while high, the paddle must not move.
- `paddleX`  in  11 signed: current paddle top-left X, from the mover.
- `Left`, `Right`, `Turbo`  out  1 each: registered commands to the mover.
- `turboLevel`  out  6: current energy, 0..`TURBO_MAX`.
- `turboExhausted`  out  1: high while turbo is locked out.

## Operation
Control FSM (`ctrl_state_t`) has three states:
- **WAIT_RELEASE**: all command outputs are 0. Moves to PLAY once `keyLeft` and `keyRight` are both 0 and `freeze` is 0. This prevents a key held during reset or during a freeze from carrying into play.
- **PLAY**: commands are generated as described below. `freeze`=1 moves to FROZEN.
- **FROZEN**: all command outputs are 0. `freeze`=0 moves to WAIT_RELEASE.

Direction arbitration in PLAY:
- `lastDir` records the key whose rising edge came most recently.
- One key held: that direction is commanded.
- Both keys held: `lastDir` wins.
- Both keys rise in the same cycle: Right wins.
- Neither key held: no direction is commanded.

Wall clamp:
- Suppress `Left` when `paddleX` ≤ `X_MIN`.
- Suppress `Right` when `paddleX` + `PADDLE_W` ≥ `X_MAX`.
- The comparison is signed and 12 bits wide, so negative `paddleX` clamps Left.

Turbo:
- `Turbo` = `keyTurbo` & (`Left` | `Right` after clamp) & !`turboExhausted` & state==PLAY.

Turbo meter:
- Updates only on `startOfFrame`.
- If `Turbo` is currently 1: `turboLevel` is decremented by 1. Reaching 0 sets `turboExhausted`.
- Otherwise: `rechargeCnt` increments. When it reaches `RECHARGE_DIV`-1 it wraps to 0 and `turboLevel` increments, saturating at `TURBO_MAX`.
- `turboExhausted` clears on the frame in which `turboLevel` becomes ≥ `TURBO_REARM`.
- In FROZEN the meter still recharges.

## Timing
Reset values:
- `Left`, `Right`, `Turbo` = 0.
- `turboLevel` = `TURBO_MAX`.
- `turboExhausted` = 0.
- State = WAIT_RELEASE, `lastDir` = Right, `rechargeCnt` = 0.

Latency: a key change, `freeze` change or `paddleX` change appears on the outputs 1 clk later (registered outputs).

Simultaneous events:
- `freeze` rising together with `startOfFrame`: the state goes to FROZEN and that frame counts as non-turbo (recharge path).
- `turboLevel` reaching 0 on `startOfFrame`: `Turbo` drops on the next clk. Energy never underflows.
- Reset mid-operation: returns to WAIT_RELEASE immediately and asynchronously, with all outputs at their reset values.

## Structure
- `paddle_pkg` holds `ctrl_state_t` (WAIT_RELEASE, PLAY, FROZEN), the `dir_t` enum, and the playfield constants 639/479.
- One sub-module, `turbo_meter`, contains the energy counter, the recharge divider and the exhausted flag. Its inputs are `clk`, `resetN`, `startOfFrame`, `drain` and `hold`.
- The FSM, arbitration and clamp stay in `paddle_ctrl`.

## Test plan
- **Reset hold:** reset with `keyRight`=1, then release reset → outputs stay 0 until `keyRight`=0; one cycle after `keyRight` rises again, `Right`=1.
- **Arbitration:** hold `keyLeft`, then 10 clks later also press `keyRight` → `Right`=1, `Left`=0; release `keyRight` → `Left`=1 on the next clk.
- **Wall clamp:** `paddleX`=575 with `keyRight`=1 → `Right`=0; `paddleX`=574 → `Right`=1; `paddleX`=-3 with `keyLeft`=1 → `Left`=0.
- **Turbo drain:** `keyRight` and `keyTurbo` held for 60 frames → `turboLevel` steps 60→0, `turboExhausted`=1, and `Turbo`=0 from the next clk.
- **Rearm:** idle after exhaustion → `turboExhausted` clears after 80 frames (`turboLevel`=20).
- **Freeze:** raise `freeze` mid-turbo on a `startOfFrame` → all outputs 0 next clk and the level does not decrement; drop `freeze` with keys held → state is WAIT_RELEASE until keys are released.
